// File: rtl/branch_predict_unit_pkg.sv
// Shared types and helpers for the branch prediction unit.
package branch_predict_unit_pkg;

    // BTB entry layout. Field widths follow these package widths, so the
    // predictor's ADDR_WIDTH / BTB_INDEX_BITS must match them.
    localparam int BPU_ADDR_WIDTH     = 32;
    localparam int BPU_BTB_INDEX_BITS = 4;
    localparam int BPU_TAG_WIDTH      = BPU_ADDR_WIDTH - BPU_BTB_INDEX_BITS - 2;

    // PHT counters come out of reset weakly not-taken.
    localparam logic [1:0] PHT_RESET_VAL = 2'b01;

    typedef struct packed {
        logic                      valid;
        logic [BPU_TAG_WIDTH-1:0]  tag;
        logic [BPU_ADDR_WIDTH-1:0] target;
        logic                      is_jump;
    } btb_entry_t;

    // 2-bit saturating counter step.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != 2'b11)
            res = cnt + 2'd1;
        else if (!taken && cnt != 2'b00)
            res = cnt - 2'd1;
        return res;
    endfunction

endpackage

// File: rtl/branch_predict_unit_btb.sv
// Direct-mapped branch target buffer: storage, tag compare and one write port.
// PCs arrive as word addresses (pc[ADDR_WIDTH-1:2]).
module branch_target_buffer
    import branch_predict_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = BPU_ADDR_WIDTH,
    parameter int BTB_INDEX_BITS = BPU_BTB_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-3:0] lookup_wpc,
    output logic                  lookup_hit,
    output logic                  lookup_is_jump,
    output logic [ADDR_WIDTH-1:0] lookup_target,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-3:0] wr_wpc,
    input  logic [ADDR_WIDTH-1:0] wr_target,
    input  logic                  wr_is_jump
);
    localparam int ENTRIES = 1 << BTB_INDEX_BITS;

    btb_entry_t                btb [ENTRIES];
    btb_entry_t                rd_entry;
    logic [BTB_INDEX_BITS-1:0] lookup_idx;
    logic [BTB_INDEX_BITS-1:0] wr_idx;
    logic [BPU_TAG_WIDTH-1:0]  lookup_tag;
    logic [BPU_TAG_WIDTH-1:0]  wr_tag;

    assign lookup_idx = lookup_wpc[BTB_INDEX_BITS-1:0];
    assign lookup_tag = lookup_wpc[ADDR_WIDTH-3:BTB_INDEX_BITS];
    assign wr_idx     = wr_wpc[BTB_INDEX_BITS-1:0];
    assign wr_tag     = wr_wpc[ADDR_WIDTH-3:BTB_INDEX_BITS];

    // Read is from registered state, so a same-cycle write is seen next cycle.
    assign rd_entry       = btb[lookup_idx];
    assign lookup_hit     = rd_entry.valid && (rd_entry.tag == lookup_tag);
    assign lookup_is_jump = rd_entry.is_jump;
    assign lookup_target  = rd_entry.target;

    // Entry storage: cleared on reset, allocate/overwrite on write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++)
                btb[i] <= '0;
        end else if (wr_en) begin
            btb[wr_idx] <= '{valid: 1'b1, tag: wr_tag, target: wr_target, is_jump: wr_is_jump};
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Gshare direction predictor with BTB target prediction, speculative global
// history with mispredict recovery, and resolution perf counters.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = BPU_ADDR_WIDTH,
    parameter int GHR_BITS       = 8,
    parameter int PHT_INDEX_BITS = 8,
    parameter int BTB_INDEX_BITS = BPU_BTB_INDEX_BITS,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    output logic [GHR_BITS-1:0]   pred_ghr,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_is_branch,
    input  logic                  update_is_jump,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic [GHR_BITS-1:0]   update_ghr,
    input  logic                  update_mispredict,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);
    localparam int PHT_SIZE = 1 << PHT_INDEX_BITS;

    logic [PHT_SIZE-1:0][1:0]    pht;
    logic [GHR_BITS-1:0]         ghr, ghr_d;
    logic [PHT_INDEX_BITS-1:0]   ghr_ext, upd_ghr_ext;
    logic [PHT_INDEX_BITS-1:0]   fetch_idx, upd_idx;
    logic                        btb_hit, btb_is_jump;
    logic [ADDR_WIDTH-1:0]       btb_target;
    logic                        btb_we, pht_we, spec_shift, recover;
    logic                        unused_upd_pc_bits;

    // Byte offset never matters for the tables.
    assign unused_upd_pc_bits = ^update_pc[1:0];

    branch_target_buffer #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .BTB_INDEX_BITS (BTB_INDEX_BITS)
    ) u_btb (
        .clk            (clk),
        .reset_n        (reset_n),
        .lookup_wpc     (fetch_pc[ADDR_WIDTH-1:2]),
        .lookup_hit     (btb_hit),
        .lookup_is_jump (btb_is_jump),
        .lookup_target  (btb_target),
        .wr_en          (btb_we),
        .wr_wpc         (update_pc[ADDR_WIDTH-1:2]),
        .wr_target      (update_target),
        .wr_is_jump     (update_is_jump)
    );

    // Zero-extend histories to PHT index width (GHR may be shorter).
    always_comb begin
        ghr_ext                   = '0;
        ghr_ext[GHR_BITS-1:0]     = ghr;
        upd_ghr_ext               = '0;
        upd_ghr_ext[GHR_BITS-1:0] = update_ghr;
    end

    assign fetch_idx = fetch_pc[PHT_INDEX_BITS+1:2] ^ ghr_ext;
    assign upd_idx   = update_pc[PHT_INDEX_BITS+1:2] ^ upd_ghr_ext;

    assign pred_taken  = btb_hit & (btb_is_jump | pht[fetch_idx][1]);
    assign pred_target = pred_taken ? btb_target : fetch_pc + ADDR_WIDTH'(4);
    assign pred_ghr    = ghr;

    assign pht_we     = update_valid & update_is_branch;
    assign btb_we     = update_valid & update_taken & (update_is_branch | update_is_jump);
    assign spec_shift = fetch_valid & btb_hit & ~btb_is_jump;
    // Non-control resolutions leave history alone even if flagged mispredicted.
    assign recover    = update_valid & update_mispredict & (update_is_branch | update_is_jump);

    // Next history: speculative shift on predicted branches, recovery overrides.
    always_comb begin
        ghr_d = ghr;
        if (spec_shift)
            ghr_d = {ghr[GHR_BITS-2:0], pred_taken};
        if (recover)
            ghr_d = update_is_branch ? {update_ghr[GHR_BITS-2:0], update_taken} : update_ghr;
    end

    // Global history register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ghr <= '0;
        else
            ghr <= ghr_d;
    end

    // PHT training with 2-bit saturating counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pht <= {PHT_SIZE{PHT_RESET_VAL}};
        else if (pht_we)
            pht[upd_idx] <= sat_update(pht[upd_idx], update_taken);
    end

    // Saturating perf counters over all resolutions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (update_valid) begin
            if (branch_count != '1)
                branch_count <= branch_count + CNT_WIDTH'(1);
            if (update_mispredict && mispredict_count != '1)
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: the driver pushes the expected lookup/counter state from a
// behavioural model each cycle; a negedge monitor pops and compares.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_ghr;
    logic        update_valid, update_is_branch, update_is_jump, update_taken, update_mispredict;
    logic [31:0] update_pc, update_target;
    logic [7:0]  update_ghr;
    logic [3:0]  branch_count, mispredict_count;

    branch_predict_unit #(.CNT_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_is_branch(update_is_branch), .update_is_jump(update_is_jump),
        .update_taken(update_taken), .update_target(update_target),
        .update_ghr(update_ghr), .update_mispredict(update_mispredict),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        tk;
        bit [31:0] tg;
        bit [7:0]  gh;
        bit [3:0]  bc;
        bit [3:0]  mc;
    } exp_t;
    exp_t q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    int        m_pht[256];
    bit        m_bv[16];
    bit [25:0] m_btag[16];
    bit [31:0] m_bt[16];
    bit        m_bj[16];
    int        m_ghr, m_bc, m_mc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 0; m_btag[i] = '0; m_bt[i] = '0; m_bj[i] = 0;
        end
        m_ghr = 0; m_bc = 0; m_mc = 0;
    endfunction

    function automatic void model_lookup(input bit [31:0] pc, output bit hit, output bit tk,
                                         output bit [31:0] tg);
        int bi, idx;
        bi  = int'((pc / 4) % 16);
        idx = int'((pc / 4) % 256) ^ m_ghr;
        hit = m_bv[bi] && (m_btag[bi] == 26'(pc / 64));
        tk  = hit && (m_bj[bi] || m_pht[idx] >= 2);
        tg  = tk ? m_bt[bi] : pc + 32'd4;
    endfunction

    // Advance the model by one clock using the inputs that were just sampled.
    function automatic void model_step();
        bit hit, tk;
        bit [31:0] tg;
        int bi, idx, ng;
        model_lookup(fetch_pc, hit, tk, tg);
        bi = int'((fetch_pc / 4) % 16);
        ng = m_ghr;
        if (fetch_valid && hit && !m_bj[bi])
            ng = (m_ghr * 2 + int'(tk)) % 256;
        if (update_valid && update_mispredict && (update_is_branch || update_is_jump))
            ng = update_is_branch ? (int'(update_ghr) * 2 + int'(update_taken)) % 256
                                  : int'(update_ghr);
        if (update_valid && update_is_branch) begin
            idx = int'((update_pc / 4) % 256) ^ int'(update_ghr);
            if (update_taken) begin
                if (m_pht[idx] < 3) m_pht[idx]++;
            end else if (m_pht[idx] > 0) m_pht[idx]--;
        end
        if (update_valid && update_taken && (update_is_branch || update_is_jump)) begin
            bi = int'((update_pc / 4) % 16);
            m_bv[bi] = 1; m_btag[bi] = 26'(update_pc / 64);
            m_bt[bi] = update_target; m_bj[bi] = update_is_jump;
        end
        if (update_valid) begin
            if (m_bc < 15) m_bc++;
            if (update_mispredict && m_mc < 15) m_mc++;
        end
        m_ghr = ng;
    endfunction

    // One cycle: publish expectation for the current inputs, clock, update model.
    task automatic cycle();
        exp_t e;
        bit hit;
        model_lookup(fetch_pc, hit, e.tk, e.tg);
        e.gh = 8'(m_ghr); e.bc = 4'(m_bc); e.mc = 4'(m_mc);
        q.push_back(e);
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic idle();
        fetch_valid = 0; update_valid = 0; update_is_branch = 0; update_is_jump = 0;
        update_taken = 0; update_mispredict = 0; update_pc = '0; update_target = '0;
        update_ghr = '0;
    endtask

    task automatic upd(input bit [31:0] pc, input bit br, input bit jmp, input bit tk,
                       input bit [31:0] tgt, input bit [7:0] gh, input bit mis);
        update_valid = 1; update_pc = pc; update_is_branch = br; update_is_jump = jmp;
        update_taken = tk; update_target = tgt; update_ghr = gh; update_mispredict = mis;
    endtask

    task automatic do_reset();
        reset_n = 0;
        model_reset();
        fetch_pc = 32'h100;
        repeat (2) cycle();
        reset_n = 1;
    endtask

    function automatic bit [31:0] rnd_pc();
        return (32'($urandom_range(0, 255)) << 2) | (32'($urandom_range(0, 1)) << 12);
    endfunction

    // Monitor: compare whatever expectation is pending against the DUT.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pred_taken", 32'(pred_taken), 32'(e.tk));
            chk("pred_target", pred_target, e.tg);
            chk("pred_ghr", 32'(pred_ghr), 32'(e.gh));
            chk("branch_count", 32'(branch_count), 32'(e.bc));
            chk("mispredict_count", 32'(mispredict_count), 32'(e.mc));
        end
    end

    initial begin
        idle();
        fetch_pc = 32'h100;
        reset_n  = 0;
        model_reset();
        @(posedge clk); #1;
        repeat (2) cycle();
        reset_n = 1;

        // Misses everywhere after reset
        for (int i = 0; i < 4; i++) begin fetch_pc = rnd_pc(); fetch_valid = 1; cycle(); end

        // Alloc
        idle(); fetch_pc = 32'h40;
        upd(32'h40, 1, 0, 1, 32'h20, 8'h00, 0); cycle();
        idle(); fetch_pc = 32'h40; cycle();

        // Saturation then two not-taken
        repeat (4) begin upd(32'h40, 1, 0, 1, 32'h20, 8'h00, 0); cycle(); end
        idle(); cycle();
        upd(32'h40, 1, 0, 0, 32'h0, 8'h00, 0); cycle();
        idle(); cycle();
        upd(32'h40, 1, 0, 0, 32'h0, 8'h00, 0); cycle();
        idle(); cycle();

        // Jump with PHT counter driven to 00; fetch hits must not shift history
        repeat (2) begin upd(32'h80, 1, 0, 0, 32'h0, 8'h00, 0); cycle(); end
        upd(32'h80, 0, 1, 1, 32'h200, 8'h00, 0); cycle();
        idle(); fetch_pc = 32'h80; fetch_valid = 1; repeat (2) cycle();

        // Recovery: re-arm 0x40, shift history with fetch hits, then mispredict
        idle();
        repeat (2) begin upd(32'h40, 1, 0, 1, 32'h20, 8'h00, 0); cycle(); end
        idle(); fetch_pc = 32'h40; fetch_valid = 1; repeat (3) cycle();
        upd(32'h40, 1, 0, 0, 32'h20, 8'h05, 1); cycle();
        idle(); fetch_pc = 32'h40; cycle();

        // Alias on same BTB index, different tag
        fetch_pc = 32'h440; cycle();
        fetch_pc = 32'hFFFF_FFFC; cycle();

        // Perf counter saturation after a mid-run reset
        do_reset();
        for (int i = 0; i < 20; i++) begin
            upd(rnd_pc(), 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
                rnd_pc(), 8'($urandom), 1'(i % 3 == 0));
            if (i % 5 == 4) begin update_is_branch = 0; update_is_jump = 0; end
            cycle();
        end
        chk("branch_count_sat", 32'(branch_count), 32'hF);
        idle();

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int kind;
            idle();
            fetch_valid = ($urandom_range(0, 3) != 0);
            fetch_pc    = rnd_pc();
            if ($urandom_range(0, 1) == 1) begin
                kind = $urandom_range(0, 4);
                upd(rnd_pc(), kind >= 2 && kind <= 3, kind == 4,
                    (kind == 4) ? 1'b1 : 1'($urandom_range(0, 1)),
                    $urandom, 8'($urandom), ($urandom_range(0, 3) == 0));
                if (kind < 2) begin update_is_branch = 0; update_is_jump = 0; end
            end
            if (i == 200) begin
                reset_n = 0;
                model_reset();
            end
            if (i == 202) reset_n = 1;
            cycle();
        end
        idle();

        // Drain with a bounded wait
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
